// File: rtl/stream_pkg.sv
// Shared beat layout, CSR map and helpers for the stream packet FIFO.
// The beat width is fixed here; the FIFO's DATA_BYTES parameter must match BEAT_BYTES.
package stream_pkg;

    localparam int BEAT_BYTES = 8;
    localparam int DATA_W     = BEAT_BYTES * 8;
    localparam int EMPTY_W    = $clog2(BEAT_BYTES);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [EMPTY_W-1:0] empty;
        logic               sop;
        logic               eop;
    } st_beat_t;

    localparam int BEAT_W = $bits(st_beat_t);

    localparam logic [1:0] CSR_FILL = 2'd0;
    localparam logic [1:0] CSR_PKT  = 2'd1;
    localparam logic [1:0] CSR_ERR  = 2'd2;

    typedef enum logic {
        FRM_IDLE   = 1'b0,
        FRM_IN_PKT = 1'b1
    } frame_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // 16-bit view of a 32-bit counter that pins at all-ones instead of truncating
    function automatic logic [15:0] sat16(input logic [31:0] value);
        return (value[31:16] != 16'd0) ? 16'hFFFF : value[15:0];
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Beat storage for the packet FIFO: register array with synchronous write and
// asynchronous read so the head beat is visible without a read cycle.
module stream_fifo_mem
    import stream_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BEAT_W-1:0] wr_beat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BEAT_W-1:0] rd_beat
);

    logic [BEAT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_beat;
        end
    end

    assign rd_beat = mem[rd_addr];

endmodule

// File: rtl/stream_packet_fifo.sv
// Avalon-ST show-ahead packet FIFO with framing policing and an Avalon-MM CSR
// slave (readLatency 1) exposing fill level, packets delivered and framing errors.
//
//   state      | meaning
//   FRM_IDLE   | between packets; next accepted beat must carry SOP or it is dropped
//   FRM_IN_PKT | inside a packet; beats are written until one with EOP
module stream_packet_fifo
    import stream_pkg::*;
#(
    parameter int DATA_BYTES = BEAT_BYTES,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BYTES*8-1:0]       stream_in_data,
    input  logic [$clog2(DATA_BYTES)-1:0] stream_in_empty,
    input  logic                          stream_in_valid,
    input  logic                          stream_in_startofpacket,
    input  logic                          stream_in_endofpacket,
    output logic                          stream_in_ready,
    output logic [DATA_BYTES*8-1:0]       stream_out_data,
    output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
    output logic                          stream_out_valid,
    output logic                          stream_out_startofpacket,
    output logic                          stream_out_endofpacket,
    input  logic                          stream_out_ready,
    input  logic [1:0]                    csr_address,
    input  logic                          csr_read,
    input  logic                          csr_write,
    input  logic [31:0]                   csr_writedata,
    output logic [31:0]                   csr_readdata,
    output logic                          csr_readdatavalid,
    output logic                          csr_waitrequest
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] count;
    frame_state_t    frame_state;

    logic [31:0] pkt_out;
    logic [31:0] err_sop;
    logic [31:0] err_orphan;

    st_beat_t beat_in;
    st_beat_t beat_out;

    logic full;
    logic accept;
    logic drop;
    logic sop_err;
    logic push;
    logic pop;
    logic err_clear;
    logic [31:0] csr_rd_mux;
    logic unused_wdata;

    assign full            = (count == (ADDR_W+1)'(DEPTH));
    assign stream_in_ready = !reset && !full;
    assign csr_waitrequest = reset;

    assign accept  = stream_in_valid && stream_in_ready;
    assign drop    = accept && !stream_in_startofpacket && (frame_state == FRM_IDLE);
    assign sop_err = accept && stream_in_startofpacket && (frame_state == FRM_IN_PKT);
    assign push    = accept && !drop;
    assign pop     = stream_out_valid && stream_out_ready;

    // The clear is a strobe; the written value carries no meaning.
    assign err_clear    = csr_write && !csr_waitrequest && (csr_address == CSR_ERR);
    assign unused_wdata = ^csr_writedata;

    assign beat_in = '{
        data:  stream_in_data,
        empty: stream_in_empty,
        sop:   stream_in_startofpacket,
        eop:   stream_in_endofpacket
    };

    stream_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_beat (beat_in),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_beat (beat_out)
    );

    assign stream_out_valid         = (count != '0);
    assign stream_out_data          = beat_out.data;
    assign stream_out_empty         = beat_out.empty;
    assign stream_out_startofpacket = beat_out.sop;
    assign stream_out_endofpacket   = beat_out.eop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_state <= FRM_IDLE;
        end else if (accept) begin
            unique case (frame_state)
                FRM_IDLE: begin
                    if (stream_in_startofpacket && !stream_in_endofpacket) begin
                        frame_state <= FRM_IN_PKT;
                    end
                end
                FRM_IN_PKT: begin
                    // A fresh SOP restarts the packet; only an EOP closes it.
                    if (stream_in_endofpacket) begin
                        frame_state <= FRM_IDLE;
                    end
                end
                default: frame_state <= FRM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_out    <= '0;
            err_sop    <= '0;
            err_orphan <= '0;
        end else begin
            if (err_clear) begin
                err_sop    <= '0;
                err_orphan <= '0;
            end else begin
                if (sop_err) begin
                    err_sop <= sat_inc(err_sop);
                end
                if (drop) begin
                    err_orphan <= sat_inc(err_orphan);
                end
            end
            if (pop && beat_out.eop) begin
                pkt_out <= sat_inc(pkt_out);
            end
        end
    end

    always_comb begin
        csr_rd_mux = 32'h0;
        unique case (csr_address)
            CSR_FILL: csr_rd_mux = 32'(count);
            CSR_PKT:  csr_rd_mux = pkt_out;
            CSR_ERR:  csr_rd_mux = {sat16(err_sop), sat16(err_orphan)};
            default:  csr_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csr_readdata      <= '0;
            csr_readdatavalid <= 1'b0;
        end else begin
            csr_readdatavalid <= csr_read;
            if (csr_read) begin
                csr_readdata <= csr_rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Self-checking bench for stream_packet_fifo: directed table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_stream_packet_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] stream_in_data;
    logic [2:0]  stream_in_empty;
    logic        stream_in_valid;
    logic        stream_in_startofpacket;
    logic        stream_in_endofpacket;
    logic        stream_in_ready;
    logic [63:0] stream_out_data;
    logic [2:0]  stream_out_empty;
    logic        stream_out_valid;
    logic        stream_out_startofpacket;
    logic        stream_out_endofpacket;
    logic        stream_out_ready;
    logic [1:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        csr_waitrequest;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stream_packet_fifo #(.DATA_BYTES(8), .DEPTH(DEPTH)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .stream_in_data           (stream_in_data),
        .stream_in_empty          (stream_in_empty),
        .stream_in_valid          (stream_in_valid),
        .stream_in_startofpacket  (stream_in_startofpacket),
        .stream_in_endofpacket    (stream_in_endofpacket),
        .stream_in_ready          (stream_in_ready),
        .stream_out_data          (stream_out_data),
        .stream_out_empty         (stream_out_empty),
        .stream_out_valid         (stream_out_valid),
        .stream_out_startofpacket (stream_out_startofpacket),
        .stream_out_endofpacket   (stream_out_endofpacket),
        .stream_out_ready         (stream_out_ready),
        .csr_address              (csr_address),
        .csr_read                 (csr_read),
        .csr_write                (csr_write),
        .csr_writedata            (csr_writedata),
        .csr_readdata             (csr_readdata),
        .csr_readdatavalid        (csr_readdatavalid),
        .csr_waitrequest          (csr_waitrequest)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  emp;
        logic        s;
        logic        e;
    } mbeat_t;

    mbeat_t  mq[$];
    bit      m_in_pkt;
    longint  m_pkt, m_esop, m_eorph;

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sd4294967295) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    function automatic logic [15:0] sat16v(input longint v);
        return (v > 64'sd65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [31:0] exp_csr(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(mq.size());
            2'd1:    return sat32(m_pkt);
            2'd2:    return {sat16v(m_esop), sat16v(m_eorph)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        m_in_pkt = 0;
        m_pkt = 0;
        m_esop = 0;
        m_eorph = 0;
    endtask

    task automatic model_edge(input logic v, input logic s, input logic e,
                              input logic [63:0] d, input logic [2:0] emp, input logic ordy);
        bit rdy;
        bit acc;
        mbeat_t b;
        rdy = (mq.size() < DEPTH);
        acc = v && rdy;
        if (mq.size() > 0 && ordy) begin
            if (mq[0].e) m_pkt++;
            void'(mq.pop_front());
        end
        b = '{d: d, emp: emp, s: s, e: e};
        if (acc) begin
            if (s) begin
                if (m_in_pkt) m_esop++;
                mq.push_back(b);
                m_in_pkt = !e;
            end else if (m_in_pkt) begin
                mq.push_back(b);
                if (e) m_in_pkt = 0;
            end else begin
                m_eorph++;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [63:0] d, input logic [2:0] emp, input logic ordy);
        stream_in_valid         = v;
        stream_in_startofpacket = s;
        stream_in_endofpacket   = e;
        stream_in_data          = d;
        stream_in_empty         = emp;
        stream_out_ready        = ordy;
    endtask

    task automatic step(input logic v, input logic s, input logic e,
                        input logic [63:0] d, input logic [2:0] emp, input logic ordy);
        drive(v, s, e, d, emp, ordy);
        #1;
        chk("in_ready", 64'(stream_in_ready), 64'(mq.size() < DEPTH));
        chk("out_valid", 64'(stream_out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_data", stream_out_data, mq[0].d);
            chk("out_empty", 64'(stream_out_empty), 64'(mq[0].emp));
            chk("out_sop", 64'(stream_out_startofpacket), 64'(mq[0].s));
            chk("out_eop", 64'(stream_out_endofpacket), 64'(mq[0].e));
        end
        @(posedge clk);
        #1;
        model_edge(v, s, e, d, emp, ordy);
    endtask

    task automatic csr_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        drive(0, 0, 0, 64'h0, 3'd0, 0);
        csr_address = a;
        csr_read    = 1'b1;
        @(posedge clk);
        #1;
        csr_read = 1'b0;
        chk({name, "_rdv"}, 64'(csr_readdatavalid), 64'd1);
        chk(name, 64'(csr_readdata), 64'(exp));
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] wd);
        drive(0, 0, 0, 64'h0, 3'd0, 0);
        csr_address   = a;
        csr_writedata = wd;
        csr_write     = 1'b1;
        @(posedge clk);
        #1;
        csr_write = 1'b0;
        if (a == 2'd2) begin
            m_esop  = 0;
            m_eorph = 0;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        csr_read  = 1'b0;
        csr_write = 1'b0;
        #1;
        chk("rst_in_ready", 64'(stream_in_ready), 64'd0);
        chk("rst_waitreq", 64'(csr_waitrequest), 64'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("rst_rdv", 64'(csr_readdatavalid), 64'd0);
        chk("rst_rdata", 64'(csr_readdata), 64'd0);
        chk("rst_out_valid", 64'(stream_out_valid), 64'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v, s, e;
        logic [63:0] d;
        logic        ordy;
        logic        x_irdy, x_ovld;
        logic [63:0] x_d;
        logic        x_sop, x_eop;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bit          rd, wr;
        logic [1:0]  a;
        logic [31:0] exp_rd;
        logic [63:0] rdata;

        reset = 1'b1;
        csr_address = 2'd0;
        csr_read = 1'b0;
        csr_write = 1'b0;
        csr_writedata = 32'h0;
        drive(0, 0, 0, 64'h0, 3'd0, 0);

        tbl[0] = '{v:1, s:1, e:0, d:64'hA1A1_0000_0000_0001, ordy:1, x_irdy:1, x_ovld:0, x_d:64'h0, x_sop:0, x_eop:0};
        tbl[1] = '{v:1, s:0, e:0, d:64'hA2A2_0000_0000_0002, ordy:1, x_irdy:1, x_ovld:1, x_d:64'hA1A1_0000_0000_0001, x_sop:1, x_eop:0};
        tbl[2] = '{v:1, s:0, e:1, d:64'hA3A3_0000_0000_0003, ordy:1, x_irdy:1, x_ovld:1, x_d:64'hA2A2_0000_0000_0002, x_sop:0, x_eop:0};
        tbl[3] = '{v:0, s:0, e:0, d:64'h0,                   ordy:1, x_irdy:1, x_ovld:1, x_d:64'hA3A3_0000_0000_0003, x_sop:0, x_eop:1};
        tbl[4] = '{v:0, s:0, e:0, d:64'h0,                   ordy:1, x_irdy:1, x_ovld:0, x_d:64'h0, x_sop:0, x_eop:0};

        // 1: three-beat packet straight through
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, 3'd0, tbl[i].ordy);
            #1;
            chk($sformatf("t1_irdy[%0d]", i), 64'(stream_in_ready), 64'(tbl[i].x_irdy));
            chk($sformatf("t1_ovld[%0d]", i), 64'(stream_out_valid), 64'(tbl[i].x_ovld));
            if (tbl[i].x_ovld) begin
                chk($sformatf("t1_data[%0d]", i), stream_out_data, tbl[i].x_d);
                chk($sformatf("t1_sop[%0d]", i), 64'(stream_out_startofpacket), 64'(tbl[i].x_sop));
                chk($sformatf("t1_eop[%0d]", i), 64'(stream_out_endofpacket), 64'(tbl[i].x_eop));
            end
            @(posedge clk);
            #1;
            model_edge(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d, 3'd0, tbl[i].ordy);
        end
        csr_rd("t1_pkt_out", 2'd1, 32'd1);

        // 2: fill to DEPTH with sink stalled
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(1, (i == 0), 0, {32'hB000_0000, 32'(i)}, 3'(i), 0);
        chk("t2_full_ready", 64'(stream_in_ready), 64'd0);
        csr_rd("t2_fill16", 2'd0, 32'd16);
        step(1, 0, 0, 64'hDEAD, 3'd0, 1);
        chk("t2_ready_after_pop", 64'(stream_in_ready), 64'd1);

        // 3: sustained push+pop at DEPTH-1 across pointer wrap
        for (int i = 0; i < 40; i++)
            step(1, 0, 0, {32'hC000_0000, 32'(i)}, 3'(i), 1);
        csr_rd("t3_fill15", 2'd0, 32'd15);
        for (int i = 0; i < DEPTH + 1; i++)
            step(0, 0, 0, 64'h0, 3'd0, 1);

        // 4: orphan beat after reset is dropped and counted
        do_reset();
        step(1, 0, 1, 64'h0BAD_0BAD, 3'd2, 1);
        step(0, 0, 0, 64'h0, 3'd0, 1);
        chk("t4_no_output", 64'(stream_out_valid), 64'd0);
        csr_rd("t4_err", 2'd2, 32'h0000_0001);
        csr_wr(2'd0, 32'hFFFF_FFFF);
        csr_rd("t4_ro_write_ignored", 2'd2, 32'h0000_0001);
        csr_wr(2'd2, 32'h0);
        csr_rd("t4_err_cleared", 2'd2, 32'h0);

        // 5: SOP inside a packet is kept and flagged
        do_reset();
        step(1, 1, 0, 64'h5151, 3'd0, 1);
        step(1, 1, 0, 64'h5252, 3'd0, 1);
        step(1, 0, 1, 64'h5353, 3'd4, 1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 64'h0, 3'd0, 1);
        csr_rd("t5_err", 2'd2, 32'h0001_0000);
        csr_rd("t5_pkt", 2'd1, 32'd1);
        csr_rd("t5_rsvd", 2'd3, 32'h0);

        // 6: reset with a partial packet buffered
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1, (i == 0), 0, {32'h6000_0000, 32'(i)}, 3'd0, 0);
        csr_rd("t6_fill5", 2'd0, 32'd5);
        do_reset();
        chk("t6_valid_after_rst", 64'(stream_out_valid), 64'd0);
        csr_rd("t6_fill0", 2'd0, 32'd0);
        csr_rd("t6_pkt0", 2'd1, 32'd0);
        csr_rd("t6_err0", 2'd2, 32'd0);
        step(1, 0, 0, 64'h7777, 3'd0, 1);
        step(0, 0, 0, 64'h0, 3'd0, 1);
        csr_rd("t6_first_needs_sop", 2'd2, 32'h0000_0001);

        // Random traffic with interleaved CSR accesses
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rd = ($urandom_range(0, 3) == 0);
            wr = !rd && ($urandom_range(0, 19) == 0);
            a  = 2'($urandom_range(0, 3));
            csr_address   = a;
            csr_read      = rd;
            csr_write     = wr;
            csr_writedata = $urandom();
            exp_rd = exp_csr(a);
            rdata  = {$urandom(), $urandom()};
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                 rdata, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            if (wr && a == 2'd2) begin
                m_esop  = 0;
                m_eorph = 0;
            end
            if (rd) begin
                chk("rnd_rdv", 64'(csr_readdatavalid), 64'd1);
                chk($sformatf("rnd_csr%0d", a), 64'(csr_readdata), 64'(exp_rd));
            end
            csr_read  = 1'b0;
            csr_write = 1'b0;
        end
        for (int i = 0; i < DEPTH + 1; i++)
            step(0, 0, 0, 64'h0, 3'd0, 1);
        for (int a2 = 0; a2 < 4; a2++)
            csr_rd($sformatf("rnd_final_csr%0d", a2), 2'(a2), exp_csr(2'(a2)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
